// File: rtl/waveform_pipe_pkg.sv
// waveform_pipe_pkg: shared constants and types for waveform_to_pipe_bram.
// Holds the FSM encoding, the number of 16-bit words per stored sample, the
// word-index type for the output stage and the BRAM entry layout.
// Optional build macro: WAVEFORM_TO_PIPE_TIMESTAMP_EN (64-bit entries that
// carry a 32-bit strobe index in front of the data).
package waveform_pipe_pkg;

    // Capture FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    localparam int unsigned BLOCK_LEN_DEFAULT = 256;

`ifdef WAVEFORM_TO_PIPE_TIMESTAMP_EN
    localparam int unsigned WORDS_PER_SAMPLE = 4;

    // ts sits in the low half so it is sent first
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] ts;
    } entry_t;
`else
    localparam int unsigned WORDS_PER_SAMPLE = 2;

    typedef struct packed {
        logic [31:0] data;
    } entry_t;
`endif

    localparam int unsigned ENTRY_W    = $bits(entry_t);
    localparam int unsigned WORD_IDX_W = $clog2(WORDS_PER_SAMPLE);

    // Index of the 16-bit word currently presented from the output stage
    typedef logic [WORD_IDX_W-1:0] word_idx_t;

    // Select one 16-bit word of an entry, word 0 = least significant
    function automatic logic [15:0] entry_word(input entry_t e, input word_idx_t idx);
        logic [ENTRY_W-1:0] bits;
        bits = e;
        return bits[{idx, 4'd0} +: 16];
    endfunction

endpackage

// File: rtl/waveform_to_pipe_bram_if.sv
// waveform_to_pipe_bram_if: capture-control and host pipe-out signals.
//   start, stop         : one-cycle control pulses
//   sample_strobe/data  : sample to record
//   pipe_read           : host pops one 16-bit word
//   pipe_dout           : current head word
//   pipe_ready          : at least one host block buffered
//   fill_level          : buffered 16-bit words (incl. output stage)
//   overflow, capturing : status flags
// master = host/sequencer side, slave = waveform_to_pipe_bram.
interface waveform_to_pipe_bram_if
    import waveform_pipe_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
);
    localparam int unsigned FILL_W = ADDR_W + 1 + WORD_IDX_W;

    logic              start;
    logic              stop;
    logic              sample_strobe;
    logic [31:0]       sample_data;
    logic              pipe_read;
    logic [15:0]       pipe_dout;
    logic              pipe_ready;
    logic [FILL_W-1:0] fill_level;
    logic              overflow;
    logic              capturing;

    modport master (
        output start, stop, sample_strobe, sample_data, pipe_read,
        input  pipe_dout, pipe_ready, fill_level, overflow, capturing
    );

    modport slave (
        input  start, stop, sample_strobe, sample_data, pipe_read,
        output pipe_dout, pipe_ready, fill_level, overflow, capturing
    );

endinterface

// File: rtl/sdp_bram.sv
// sdp_bram: simple dual-port RAM, one write port and one read port with a
// registered (1-cycle) read output. The array is not reset.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata valid the cycle after re
//   rdata        : registered read data, holds when re is low
module sdp_bram #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port and registered read port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/waveform_to_pipe_bram.sv
// waveform_to_pipe_bram: records samples on a strobe into a BRAM FIFO and
// serialises each entry as 16-bit words (least significant first) for a
// block-throttled host pipe-out.
//   clk   : single clock for capture and host pipe
//   reset : synchronous, active-high
//   bus   : waveform_to_pipe_bram_if.slave (control, sample, pipe, flags)
// Optional macro WAVEFORM_TO_PIPE_TIMESTAMP_EN: each entry also carries a
// 32-bit strobe index, sent ahead of the data.
module waveform_to_pipe_bram
    import waveform_pipe_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned BLOCK_LEN   = BLOCK_LEN_DEFAULT,
    parameter int unsigned MAX_SAMPLES = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    waveform_to_pipe_bram_if.slave  bus
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned FILL_W = ADDR_W + 1 + WORD_IDX_W;
    localparam word_idx_t   LAST_WORD = word_idx_t'(WORDS_PER_SAMPLE - 1);

    logic [1:0]        state, state_n;
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_n;
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_n;
    logic [PTR_W-1:0]  entry_cnt, entry_cnt_n;
    logic [31:0]       sample_cnt, sample_cnt_n;
    logic              q_valid, q_valid_n;
    logic              o_valid, o_valid_n;
    entry_t            o_entry, o_entry_n;
    word_idx_t         half, half_n;
    logic [FILL_W-1:0] fill, fill_n;
    logic              overflow_r, overflow_n;
    logic [15:0]       dout_r, dout_n;
    logic              ready_r, ready_n;
    logic              capturing_r, capturing_n;

    entry_t            wr_entry;
    entry_t            q_data;
    logic              full, strobe_cap, wr_en, adv, pop, load_o, rd_en, max_hit;

`ifdef WAVEFORM_TO_PIPE_TIMESTAMP_EN
    assign wr_entry = '{data: bus.sample_data, ts: sample_cnt};
`else
    assign wr_entry = '{data: bus.sample_data};
`endif

    // entry_cnt includes entries already moved into the prefetch/output stages
    assign full       = (entry_cnt == PTR_W'(DEPTH));
    assign strobe_cap = (state == ST_CAPTURE) && bus.sample_strobe && !bus.start;
    assign wr_en      = strobe_cap && !full;
    assign adv        = bus.pipe_read && o_valid && !bus.start;
    assign pop        = adv && (half == LAST_WORD);
    assign load_o     = q_valid && (!o_valid || pop) && !bus.start;
    assign rd_en      = (wr_ptr != rd_ptr) && (!q_valid || load_o) && !bus.start;
    assign max_hit    = (MAX_SAMPLES != 0) && strobe_cap
                        && ((sample_cnt + 32'd1) == MAX_SAMPLES);

    // BRAM output register acts as the first prefetch stage (q_valid)
    sdp_bram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_bram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (wr_entry),
        .re    (rd_en),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (q_data)
    );

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_n      = state;
        wr_ptr_n     = wr_ptr;
        rd_ptr_n     = rd_ptr;
        entry_cnt_n  = entry_cnt;
        sample_cnt_n = sample_cnt;
        q_valid_n    = q_valid;
        o_valid_n    = o_valid;
        o_entry_n    = o_entry;
        half_n       = half;
        fill_n       = fill;
        overflow_n   = overflow_r;
        dout_n       = dout_r;
        ready_n      = ready_r;
        capturing_n  = capturing_r;

        case (state)
            ST_IDLE:    state_n = ST_IDLE;
            ST_CAPTURE: if (bus.stop || max_hit) state_n = ST_DRAIN;
            ST_DRAIN:   if (entry_cnt == '0) state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase

        if (wr_en) wr_ptr_n = wr_ptr + PTR_W'(1);
        if (rd_en) rd_ptr_n = rd_ptr + PTR_W'(1);

        q_valid_n = rd_en || (q_valid && !load_o);

        if (load_o) begin
            o_entry_n = q_data;
            o_valid_n = 1'b1;
            half_n    = '0;
        end else if (pop) begin
            o_valid_n = 1'b0;
            half_n    = '0;
        end else if (adv) begin
            half_n = half + word_idx_t'(1);
        end

        entry_cnt_n = entry_cnt + PTR_W'(wr_en) - PTR_W'(pop);
        fill_n      = fill + (wr_en ? FILL_W'(WORDS_PER_SAMPLE) : '0) - FILL_W'(adv);

        // Dropped samples still advance the count
        if (strobe_cap) begin
            sample_cnt_n = sample_cnt + 32'd1;
            if (full) overflow_n = 1'b1;
        end

        // start overrides everything, including a same-cycle stop
        if (bus.start) begin
            state_n      = ST_CAPTURE;
            wr_ptr_n     = '0;
            rd_ptr_n     = '0;
            entry_cnt_n  = '0;
            sample_cnt_n = '0;
            q_valid_n    = 1'b0;
            o_valid_n    = 1'b0;
            half_n       = '0;
            fill_n       = '0;
            overflow_n   = 1'b0;
        end

        if (o_valid_n) dout_n = entry_word(o_entry_n, half_n);
        ready_n     = (32'(fill_n) >= BLOCK_LEN);
        capturing_n = (state_n == ST_CAPTURE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            entry_cnt   <= '0;
            sample_cnt  <= '0;
            q_valid     <= 1'b0;
            o_valid     <= 1'b0;
            o_entry     <= '0;
            half        <= '0;
            fill        <= '0;
            overflow_r  <= 1'b0;
            dout_r      <= '0;
            ready_r     <= 1'b0;
            capturing_r <= 1'b0;
        end else begin
            state       <= state_n;
            wr_ptr      <= wr_ptr_n;
            rd_ptr      <= rd_ptr_n;
            entry_cnt   <= entry_cnt_n;
            sample_cnt  <= sample_cnt_n;
            q_valid     <= q_valid_n;
            o_valid     <= o_valid_n;
            o_entry     <= o_entry_n;
            half        <= half_n;
            fill        <= fill_n;
            overflow_r  <= overflow_n;
            dout_r      <= dout_n;
            ready_r     <= ready_n;
            capturing_r <= capturing_n;
        end
    end

    assign bus.pipe_dout  = dout_r;
    assign bus.pipe_ready = ready_r;
    assign bus.fill_level = fill;
    assign bus.overflow   = overflow_r;
    assign bus.capturing  = capturing_r;

endmodule

// File: tb/tb_waveform_to_pipe_bram.sv
// tb_waveform_to_pipe_bram: self-checking bench for waveform_to_pipe_bram.
// Three instances: default (ADDR_W=10), small FIFO (ADDR_W=4, BLOCK_LEN=8)
// and auto-stop (MAX_SAMPLES=4). A word-queue model of the host-visible
// stream predicts every output.
module tb_waveform_to_pipe_bram;
    import waveform_pipe_pkg::*;

    localparam int unsigned W = WORDS_PER_SAMPLE;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int          cur = 0;
    logic        start_d = 1'b0, stop_d = 1'b0, strobe_d = 1'b0, read_d = 1'b0;
    logic [31:0] data_d = '0;

    waveform_to_pipe_bram_if #(.ADDR_W(10)) b0 ();
    waveform_to_pipe_bram_if #(.ADDR_W(4))  b1 ();
    waveform_to_pipe_bram_if #(.ADDR_W(10)) b2 ();

    waveform_to_pipe_bram #(.ADDR_W(10), .BLOCK_LEN(256), .MAX_SAMPLES(0))
        u_dut0 (.clk(clk), .reset(reset), .bus(b0));
    waveform_to_pipe_bram #(.ADDR_W(4), .BLOCK_LEN(8), .MAX_SAMPLES(0))
        u_dut1 (.clk(clk), .reset(reset), .bus(b1));
    waveform_to_pipe_bram #(.ADDR_W(10), .BLOCK_LEN(256), .MAX_SAMPLES(4))
        u_dut2 (.clk(clk), .reset(reset), .bus(b2));

    // Stimulus reaches only the selected instance
    assign b0.start = (cur == 0) && start_d;
    assign b1.start = (cur == 1) && start_d;
    assign b2.start = (cur == 2) && start_d;
    assign b0.stop = (cur == 0) && stop_d;
    assign b1.stop = (cur == 1) && stop_d;
    assign b2.stop = (cur == 2) && stop_d;
    assign b0.sample_strobe = (cur == 0) && strobe_d;
    assign b1.sample_strobe = (cur == 1) && strobe_d;
    assign b2.sample_strobe = (cur == 2) && strobe_d;
    assign b0.pipe_read = (cur == 0) && read_d;
    assign b1.pipe_read = (cur == 1) && read_d;
    assign b2.pipe_read = (cur == 2) && read_d;
    assign b0.sample_data = data_d;
    assign b1.sample_data = data_d;
    assign b2.sample_data = data_d;

    logic [15:0] o_dout;
    logic [31:0] o_fill;
    logic        o_ready, o_ovf, o_cap;

    always_comb begin
        case (cur)
            1: begin
                o_dout = b1.pipe_dout; o_fill = 32'(b1.fill_level);
                o_ready = b1.pipe_ready; o_ovf = b1.overflow; o_cap = b1.capturing;
            end
            2: begin
                o_dout = b2.pipe_dout; o_fill = 32'(b2.fill_level);
                o_ready = b2.pipe_ready; o_ovf = b2.overflow; o_cap = b2.capturing;
            end
            default: begin
                o_dout = b0.pipe_dout; o_fill = 32'(b0.fill_level);
                o_ready = b0.pipe_ready; o_ovf = b0.overflow; o_cap = b0.capturing;
            end
        endcase
    end

    // Reference model: the host-visible word stream plus flags
    logic [15:0] mq[$];
    bit          mcap = 1'b0;
    bit          movf = 1'b0;
    int unsigned sidx = 0;
    int unsigned m_depth = 1024;
    int unsigned m_block = 256;
    int unsigned m_max = 0;

    int unsigned checks = 0, passes = 0, fails = 0;

    function automatic int unsigned held_entries();
        return (mq.size() + W - 1) / W;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic select(input int k);
        cur = k;
        m_depth = (k == 1) ? 16 : 1024;
        m_block = (k == 1) ? 8 : 256;
        m_max   = (k == 2) ? 4 : 0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit sb,
                              input logic [31:0] d, input bit rd);
        int unsigned held;
        logic [31:0] ts;
        held = held_entries();
        if (st) begin
            mq.delete();
            movf = 1'b0;
            sidx = 0;
            mcap = 1'b1;
        end else begin
            if (rd && mq.size() != 0) void'(mq.pop_front());
            if (mcap && sb) begin
                if (held < m_depth) begin
                    ts = sidx;
`ifdef WAVEFORM_TO_PIPE_TIMESTAMP_EN
                    mq.push_back(ts[15:0]);
                    mq.push_back(ts[31:16]);
`endif
                    mq.push_back(d[15:0]);
                    mq.push_back(d[31:16]);
                end else begin
                    movf = 1'b1;
                end
                sidx++;
                if (m_max != 0 && sidx == m_max) mcap = 1'b0;
            end
            if (sp) mcap = 1'b0;
        end
    endtask

    task automatic cycle(input bit st, input bit sp, input bit sb,
                         input logic [31:0] d, input bit rd, input string tag);
        start_d = st; stop_d = sp; strobe_d = sb; data_d = d; read_d = rd;
        if (rd && mq.size() != 0) check({tag, "/dout"}, 32'(o_dout), 32'(mq[0]));
        model_step(st, sp, sb, d, rd);
        @(posedge clk); #1;
        start_d = 1'b0; stop_d = 1'b0; strobe_d = 1'b0; read_d = 1'b0;
        check({tag, "/fill"},  o_fill, 32'(mq.size()));
        check({tag, "/cap"},   32'(o_cap), 32'(mcap));
        check({tag, "/ovf"},   32'(o_ovf), 32'(movf));
        check({tag, "/ready"}, 32'(o_ready), 32'(mq.size() >= m_block));
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, tag);
    endtask

    task automatic drain_all(input string tag);
        for (int i = 0; i < 5000 && mq.size() != 0; i++)
            cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, tag);
        check({tag, "/empty"}, 32'(mq.size()), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        mq.delete();
        mcap = 1'b0; movf = 1'b0; sidx = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        check({tag, "/dout"},  32'(o_dout), 32'd0);
        check({tag, "/fill"},  o_fill, 32'd0);
        check({tag, "/cap"},   32'(o_cap), 32'd0);
        check({tag, "/ovf"},   32'(o_ovf), 32'd0);
        check({tag, "/ready"}, 32'(o_ready), 32'd0);
    endtask

    initial begin
        logic [31:0] base;
        bit          sb, rd;

        // Reset state
        select(0);
        @(posedge clk); #1;
        do_reset("reset");

        // Strobes in IDLE are ignored; three fixed samples, six reads
        cycle(1'b0, 1'b0, 1'b1, $urandom(), 1'b0, "idle_strobe");
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, "t1_start");
        cycle(1'b0, 1'b0, 1'b1, 32'h3F80_0000, 1'b0, "t1_wr");
        cycle(1'b0, 1'b0, 1'b1, 32'h4000_0000, 1'b0, "t1_wr");
        cycle(1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, "t1_wr");
        idle(3, "t1_wait");
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, "t1_rd");

        // start+stop together: start wins; 128 samples then one block
        cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, "t2_start");
        base = $urandom();
        for (int i = 0; i < 128; i++)
            cycle(1'b0, 1'b0, 1'b1, base + 32'(i), 1'b0, "t2_wr");
        idle(3, "t2_wait");
        for (int i = 0; i < 256; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, "t2_blk");

        // Small FIFO overflow
        select(1);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, "t3_start");
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1, $urandom(), 1'b0, "t3_wr");
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, "t3_stop");
        idle(3, "t3_wait");
        drain_all("t3_rd");
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, "t3_restart");
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, "t3_stop2");

        // Sustained concurrent write/read
        select(0);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, "t4_start");
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, $urandom(), 1'b0, "t4_pre");
        idle(3, "t4_wait");
        for (int i = 0; i < 50; i++) begin
            cycle(1'b0, 1'b0, (i % 2) == 0, $urandom(), 1'b1, "t4_sus");
`ifndef WAVEFORM_TO_PIPE_TIMESTAMP_EN
            if ((i % 2) == 1) check("t4_const_fill", o_fill, 32'd8);
`endif
        end

        // Random strobes and reads while capturing
        for (int i = 0; i < 300; i++) begin
            sb = ($urandom_range(0, 1) == 1);
            rd = (held_entries() >= 3) && ($urandom_range(0, 9) < 6);
            cycle(1'b0, 1'b0, sb, $urandom(), rd, "t4_rand");
        end
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, "t4_stop");
        idle(3, "t4_wait2");
        drain_all("t4_drain");

        // Auto-stop after MAX_SAMPLES
        select(2);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, "t5_start");
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, $urandom(), 1'b0, "t5_wr");
        check("t5_words", o_fill, 32'(4 * W));
        idle(3, "t5_wait");
        drain_all("t5_rd");
        idle(2, "t5_settle");
        check("t5_state_idle", 32'(u_dut2.state), 32'(ST_IDLE));
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, "t5_start2");
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, $urandom(), 1'b0, "t5_wr2");
        idle(3, "t5_wait2");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, "t5_rd2");
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, "t5_flush");
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, "t5_stop");

        // Reset in the middle of a read-out
        select(0);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, "t6_start");
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, $urandom(), 1'b0, "t6_wr");
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, "t6_stop");
        idle(3, "t6_wait");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, "t6_rd");
        do_reset("t6_reset");
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, "t6_rd_empty");
        check("t6_dout_hold", 32'(o_dout), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
